// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that lends one shared W-bit holding register to N requesters.
// Define ARB_TIMEOUT_EN to bound each ownership to MAX_HOLD cycles and pulse timeout on forced release.
module shared_reg_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 16,
  localparam int OW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [OW-1:0]  owner_id,
  output logic [W-1:0]   q,
  output logic           busy,
  output logic           stat,
  output logic           timeout
);

  typedef enum logic {S_IDLE, S_OWN} state_e;

  state_e        state_q;
  logic [N-1:0]  gnt_q;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] last_q;
  logic [W-1:0]  data_q;
  logic [W-1:0]  wdata_a [N];
  logic [OW-1:0] win_d;
  logic          win_vld_d;
  logic [OW-1:0] scan_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_unpack
      assign wdata_a[gi] = wdata[gi*W +: W];
    end
  endgenerate

  // First requester at or after last+1 (wrapping) wins.
  always_comb begin
    win_d     = '0;
    win_vld_d = 1'b0;
    scan_idx  = '0;
    for (int k = 1; k <= N; k++) begin
      scan_idx = OW'((int'(last_q) + k) % N);
      if (!win_vld_d && req[scan_idx]) begin
        win_vld_d = 1'b1;
        win_d     = scan_idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q;
  logic          timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= OW'(N - 1);
      data_q  <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            state_q <= S_OWN;
            gnt_q   <= {{(N-1){1'b0}}, 1'b1} << win_d;
            owner_q <= win_d;
            last_q  <= win_d;
            data_q  <= wdata_a[win_d];
`ifdef ARB_TIMEOUT_EN
            hold_q  <= HW'(1);
`endif
          end
        end
        S_OWN: begin
          // A dropped request releases without sampling that cycle's data.
          if (!req[owner_q]) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
`ifdef ARB_TIMEOUT_EN
          end else if (hold_q == HW'(MAX_HOLD)) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            timeout_q <= 1'b1;
            data_q    <= wdata_a[owner_q];
`endif
          end else begin
            data_q <= wdata_a[owner_q];
`ifdef ARB_TIMEOUT_EN
            hold_q <= hold_q + 1'b1;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign owner_id = owner_q;
  assign q        = data_q;
  assign busy     = (state_q == S_OWN);
  assign stat     = ~busy;
`ifdef ARB_TIMEOUT_EN
  assign timeout  = timeout_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter (N=4, W=8, MAX_HOLD=4); timeout scenarios need ARB_TIMEOUT_EN.
module tb_shared_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   gnt;
  logic [1:0]     owner_id;
  logic [W-1:0]   q;
  logic           busy;
  logic           stat;
  logic           timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wd;
    logic [16:0] exp;
  } row_t;

  logic [16:0] sb [$];

  shared_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata), .gnt(gnt),
    .owner_id(owner_id), .q(q), .busy(busy), .stat(stat), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Expected outputs packed as {gnt, owner_id, q, busy, stat, timeout}.
  function automatic logic [16:0] ex(logic [3:0] g, logic [1:0] o, logic [7:0] qq, logic b, logic t);
    return {g, o, qq, b, ~b, t};
  endfunction

  function automatic logic [31:0] wd4(logic [7:0] d3, logic [7:0] d2, logic [7:0] d1, logic [7:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic row_t r(logic rs, logic [3:0] rq, logic [31:0] wd, logic [16:0] e);
    row_t x;
    x.rst = rs; x.req = rq; x.wd = wd; x.exp = e;
    return x;
  endfunction

  task automatic test_reset();
    row_t rows[$];
    logic [16:0] e, obs;
    rows.push_back(r(1'b1, 4'b1111, wd4(8'h11, 8'h22, 8'h33, 8'h44), ex(4'b0000, 2'd0, 8'h00, 1'b0, 1'b0)));
    rows.push_back(r(1'b1, 4'b0000, wd4(8'h00, 8'h00, 8'h00, 8'h00), ex(4'b0000, 2'd0, 8'h00, 1'b0, 1'b0)));
    foreach (rows[i]) begin
      rst = rows[i].rst; req = rows[i].req; wdata = rows[i].wd; sb.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {gnt, owner_id, q, busy, stat, timeout}; checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset step %0d: got gnt=%b own=%0d q=%h busy=%b stat=%b to=%b, expected gnt=%b own=%0d q=%h busy=%b stat=%b to=%b",
                 i, gnt, owner_id, q, busy, stat, timeout, e[16:13], e[12:11], e[10:3], e[2], e[1], e[0]);
      end else $display("ok reset step %0d gnt=%b q=%h", i, gnt, q);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    row_t rows[$];
    logic [16:0] e, obs;
    rows.push_back(r(1'b0, 4'b0001, wd4(8'h00, 8'h00, 8'h00, 8'hA5), ex(4'b0001, 2'd0, 8'hA5, 1'b1, 1'b0)));
    rows.push_back(r(1'b0, 4'b0001, wd4(8'h00, 8'h00, 8'h00, 8'h5A), ex(4'b0001, 2'd0, 8'h5A, 1'b1, 1'b0)));
    rows.push_back(r(1'b0, 4'b0000, wd4(8'h00, 8'h00, 8'h00, 8'h99), ex(4'b0000, 2'd0, 8'h5A, 1'b0, 1'b0)));
    rows.push_back(r(1'b0, 4'b0000, wd4(8'h00, 8'h00, 8'h00, 8'h77), ex(4'b0000, 2'd0, 8'h5A, 1'b0, 1'b0)));
    foreach (rows[i]) begin
      rst = rows[i].rst; req = rows[i].req; wdata = rows[i].wd; sb.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {gnt, owner_id, q, busy, stat, timeout}; checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL basic step %0d: got gnt=%b own=%0d q=%h busy=%b stat=%b to=%b, expected gnt=%b own=%0d q=%h busy=%b stat=%b to=%b",
                 i, gnt, owner_id, q, busy, stat, timeout, e[16:13], e[12:11], e[10:3], e[2], e[1], e[0]);
      end else $display("ok basic step %0d gnt=%b q=%h", i, gnt, q);
    end
  endtask

  task automatic test_round_robin();
    row_t rows[$];
    logic [16:0] e, obs;
    logic [31:0] w;
    w = wd4(8'h40, 8'h30, 8'h20, 8'h10);
    rows.push_back(r(1'b1, 4'b0000, w, ex(4'b0000, 2'd0, 8'h00, 1'b0, 1'b0)));
    for (int k = 0; k < 4; k++) begin
      logic [3:0] oh;
      logic [7:0] dv;
      oh = 4'b0001 << k;
      dv = 8'(8'h10 * (k + 1));
      rows.push_back(r(1'b0, 4'b1111, w, ex(oh, 2'(k), dv, 1'b1, 1'b0)));
      rows.push_back(r(1'b0, 4'b1111, w, ex(oh, 2'(k), dv, 1'b1, 1'b0)));
      rows.push_back(r(1'b0, 4'b1111 & ~oh, w, ex(4'b0000, 2'(k), dv, 1'b0, 1'b0)));
    end
    rows.push_back(r(1'b0, 4'b1111, w, ex(4'b0001, 2'd0, 8'h10, 1'b1, 1'b0)));
    rows.push_back(r(1'b0, 4'b0000, w, ex(4'b0000, 2'd0, 8'h10, 1'b0, 1'b0)));
    foreach (rows[i]) begin
      rst = rows[i].rst; req = rows[i].req; wdata = rows[i].wd; sb.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {gnt, owner_id, q, busy, stat, timeout}; checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL round_robin step %0d: got gnt=%b own=%0d q=%h busy=%b stat=%b to=%b, expected gnt=%b own=%0d q=%h busy=%b stat=%b to=%b",
                 i, gnt, owner_id, q, busy, stat, timeout, e[16:13], e[12:11], e[10:3], e[2], e[1], e[0]);
      end else $display("ok round_robin step %0d gnt=%b own=%0d q=%h", i, gnt, owner_id, q);
    end
  endtask

  task automatic test_hold_track();
    row_t rows[$];
    logic [16:0] e, obs;
    rows.push_back(r(1'b0, 4'b0101, wd4(8'h00, 8'h01, 8'h00, 8'hEE), ex(4'b0100, 2'd2, 8'h01, 1'b1, 1'b0)));
    rows.push_back(r(1'b0, 4'b0101, wd4(8'h00, 8'h02, 8'h00, 8'hEE), ex(4'b0100, 2'd2, 8'h02, 1'b1, 1'b0)));
    rows.push_back(r(1'b0, 4'b0101, wd4(8'h00, 8'h03, 8'h00, 8'hEE), ex(4'b0100, 2'd2, 8'h03, 1'b1, 1'b0)));
    rows.push_back(r(1'b0, 4'b0001, wd4(8'h00, 8'h04, 8'h00, 8'hEE), ex(4'b0000, 2'd2, 8'h03, 1'b0, 1'b0)));
    rows.push_back(r(1'b0, 4'b0001, wd4(8'h00, 8'h05, 8'h00, 8'hEE), ex(4'b0001, 2'd0, 8'hEE, 1'b1, 1'b0)));
    rows.push_back(r(1'b0, 4'b0000, wd4(8'h00, 8'h05, 8'h00, 8'hEF), ex(4'b0000, 2'd0, 8'hEE, 1'b0, 1'b0)));
    foreach (rows[i]) begin
      rst = rows[i].rst; req = rows[i].req; wdata = rows[i].wd; sb.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {gnt, owner_id, q, busy, stat, timeout}; checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL hold_track step %0d: got gnt=%b own=%0d q=%h busy=%b stat=%b to=%b, expected gnt=%b own=%0d q=%h busy=%b stat=%b to=%b",
                 i, gnt, owner_id, q, busy, stat, timeout, e[16:13], e[12:11], e[10:3], e[2], e[1], e[0]);
      end else $display("ok hold_track step %0d gnt=%b q=%h", i, gnt, q);
    end
  endtask

  task automatic test_reset_mid_own();
    row_t rows[$];
    logic [16:0] e, obs;
    logic [31:0] w;
    w = wd4(8'h44, 8'h33, 8'h3C, 8'h11);
    rows.push_back(r(1'b0, 4'b0010, w, ex(4'b0010, 2'd1, 8'h3C, 1'b1, 1'b0)));
    rows.push_back(r(1'b0, 4'b0010, w, ex(4'b0010, 2'd1, 8'h3C, 1'b1, 1'b0)));
    rows.push_back(r(1'b1, 4'b0010, w, ex(4'b0000, 2'd0, 8'h00, 1'b0, 1'b0)));
    rows.push_back(r(1'b0, 4'b1111, w, ex(4'b0001, 2'd0, 8'h11, 1'b1, 1'b0)));
    rows.push_back(r(1'b0, 4'b0000, w, ex(4'b0000, 2'd0, 8'h11, 1'b0, 1'b0)));
    foreach (rows[i]) begin
      rst = rows[i].rst; req = rows[i].req; wdata = rows[i].wd; sb.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {gnt, owner_id, q, busy, stat, timeout}; checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid_own step %0d: got gnt=%b own=%0d q=%h busy=%b stat=%b to=%b, expected gnt=%b own=%0d q=%h busy=%b stat=%b to=%b",
                 i, gnt, owner_id, q, busy, stat, timeout, e[16:13], e[12:11], e[10:3], e[2], e[1], e[0]);
      end else $display("ok reset_mid_own step %0d gnt=%b q=%h", i, gnt, q);
    end
    rst = 1'b0;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    row_t rows[$];
    logic [16:0] e, obs;
    rows.push_back(r(1'b1, 4'b0000, wd4(8'h00, 8'h00, 8'hB0, 8'hA0), ex(4'b0000, 2'd0, 8'h00, 1'b0, 1'b0)));
    for (int k = 0; k < 5; k++) begin
      logic [7:0] dv;
      dv = 8'(8'hA0 + k);
      if (k < 4) rows.push_back(r(1'b0, 4'b0011, wd4(8'h00, 8'h00, 8'hB0, dv), ex(4'b0001, 2'd0, dv, 1'b1, 1'b0)));
      else       rows.push_back(r(1'b0, 4'b0011, wd4(8'h00, 8'h00, 8'hB0, dv), ex(4'b0000, 2'd0, dv, 1'b0, 1'b1)));
    end
    rows.push_back(r(1'b0, 4'b0011, wd4(8'h00, 8'h00, 8'hB0, 8'hA5), ex(4'b0010, 2'd1, 8'hB0, 1'b1, 1'b0)));
    rows.push_back(r(1'b0, 4'b0000, wd4(8'h00, 8'h00, 8'hB1, 8'hA5), ex(4'b0000, 2'd1, 8'hB0, 1'b0, 1'b0)));
    foreach (rows[i]) begin
      rst = rows[i].rst; req = rows[i].req; wdata = rows[i].wd; sb.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {gnt, owner_id, q, busy, stat, timeout}; checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL timeout step %0d: got gnt=%b own=%0d q=%h busy=%b stat=%b to=%b, expected gnt=%b own=%0d q=%h busy=%b stat=%b to=%b",
                 i, gnt, owner_id, q, busy, stat, timeout, e[16:13], e[12:11], e[10:3], e[2], e[1], e[0]);
      end else $display("ok timeout step %0d gnt=%b q=%h to=%b", i, gnt, q, timeout);
    end
    rst = 1'b0;
  endtask

  task automatic test_release_at_limit();
    row_t rows[$];
    logic [16:0] e, obs;
    rows.push_back(r(1'b0, 4'b0100, wd4(8'h00, 8'hC0, 8'h00, 8'h00), ex(4'b0100, 2'd2, 8'hC0, 1'b1, 1'b0)));
    rows.push_back(r(1'b0, 4'b0100, wd4(8'h00, 8'hC1, 8'h00, 8'h00), ex(4'b0100, 2'd2, 8'hC1, 1'b1, 1'b0)));
    rows.push_back(r(1'b0, 4'b0100, wd4(8'h00, 8'hC2, 8'h00, 8'h00), ex(4'b0100, 2'd2, 8'hC2, 1'b1, 1'b0)));
    rows.push_back(r(1'b0, 4'b0100, wd4(8'h00, 8'hC3, 8'h00, 8'h00), ex(4'b0100, 2'd2, 8'hC3, 1'b1, 1'b0)));
    rows.push_back(r(1'b0, 4'b0000, wd4(8'h00, 8'hC4, 8'h00, 8'h00), ex(4'b0000, 2'd2, 8'hC3, 1'b0, 1'b0)));
    rows.push_back(r(1'b0, 4'b0000, wd4(8'h00, 8'hC5, 8'h00, 8'h00), ex(4'b0000, 2'd2, 8'hC3, 1'b0, 1'b0)));
    foreach (rows[i]) begin
      rst = rows[i].rst; req = rows[i].req; wdata = rows[i].wd; sb.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); obs = {gnt, owner_id, q, busy, stat, timeout}; checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL release_at_limit step %0d: got gnt=%b own=%0d q=%h busy=%b stat=%b to=%b, expected gnt=%b own=%0d q=%h busy=%b stat=%b to=%b",
                 i, gnt, owner_id, q, busy, stat, timeout, e[16:13], e[12:11], e[10:3], e[2], e[1], e[0]);
      end else $display("ok release_at_limit step %0d gnt=%b q=%h to=%b", i, gnt, q, timeout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_hold_track();
    test_reset_mid_own();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
    test_release_at_limit();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
